// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - MIPS instruction decoder with register-file operand fetch and timeout
module instr_decode #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        rf_start,
   output logic [4:0]  rf_read_addr_s,
   output logic [4:0]  rf_read_addr_t,
   input  logic        rf_finish,
   input  logic [31:0] rf_data_s,
   input  logic [31:0] rf_data_t,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] op_a,
   output logic [31:0] op_b,
   output logic [31:0] imm_ext,
   output logic [4:0]  dest_addr,
   output logic        reg_write,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic        illegal,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

   // Last READ cycle index; reaching it without rf_finish means the read timed out
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        out_valid_q, out_valid_d;
   logic        err_q, err_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [31:0] imm_q, imm_d;
   logic [4:0]  dest_q, dest_d;
   logic        rw_q, rw_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [5:0]  funct_q, funct_d;
   logic        illegal_q, illegal_d;

   logic [5:0]  dec_op;
   logic [4:0]  dec_dest;
   logic        dec_rw;
   logic        dec_illegal;
   logic [31:0] dec_imm;
   logic        unused_shamt;

   // The shamt field plays no part in decode
   assign unused_shamt = ^instr_q[10:6];

   // Decode the latched instruction; the result is captured together with the operands
   always_comb begin
      dec_op      = instr_q[31:26];
      dec_dest    = 5'd0;
      dec_rw      = 1'b0;
      dec_illegal = 1'b0;
      dec_imm     = {{16{instr_q[15]}}, instr_q[15:0]};
      case (dec_op)
         6'h00: begin
            dec_dest = instr_q[15:11];
            dec_rw   = (instr_q[5:0] != 6'h08);
         end
         6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: begin
            dec_dest = instr_q[20:16];
            dec_rw   = 1'b1;
         end
         6'h2B, 6'h04, 6'h05, 6'h02: dec_rw = 1'b0;
         6'h03: begin
            dec_dest = 5'd31;
            dec_rw   = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      // Writes to $zero are architecturally discarded
      if (dec_dest == 5'd0) dec_rw = 1'b0;
      case (dec_op)
         6'h0C, 6'h0D, 6'h0E: dec_imm = {16'h0000, instr_q[15:0]};
         6'h0F:               dec_imm = {instr_q[15:0], 16'h0000};
         default:             ;
      endcase
   end

   // Next-state and capture logic for the IDLE -> READ -> HOLD handshake
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      cnt_d       = 8'd0;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      imm_d       = imm_q;
      dest_d      = dest_q;
      rw_d        = rw_q;
      opcode_d    = opcode_q;
      funct_d     = funct_q;
      illegal_d   = illegal_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               instr_d = instr;
               state_d = READ;
            end
         end
         READ: begin
            if (rf_finish) begin
               op_a_d      = rf_data_s;
               op_b_d      = rf_data_t;
               imm_d       = dec_imm;
               dest_d      = dec_dest;
               rw_d        = dec_rw;
               opcode_d    = dec_op;
               funct_d     = instr_q[5:0];
               illegal_d   = dec_illegal;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and captured-bundle registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         instr_q     <= 32'd0;
         cnt_q       <= 8'd0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         op_a_q      <= 32'd0;
         op_b_q      <= 32'd0;
         imm_q       <= 32'd0;
         dest_q      <= 5'd0;
         rw_q        <= 1'b0;
         opcode_q    <= 6'd0;
         funct_q     <= 6'd0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         imm_q       <= imm_d;
         dest_q      <= dest_d;
         rw_q        <= rw_d;
         opcode_q    <= opcode_d;
         funct_q     <= funct_d;
         illegal_q   <= illegal_d;
      end
   end

   assign in_ready       = (state_q == IDLE);
   assign rf_start       = (state_q == READ);
   assign rf_read_addr_s = instr_q[25:21];
   assign rf_read_addr_t = instr_q[20:16];
   assign out_valid      = out_valid_q;
   assign op_a           = op_a_q;
   assign op_b           = op_b_q;
   assign imm_ext        = imm_q;
   assign dest_addr      = dest_q;
   assign reg_write      = rw_q;
   assign opcode         = opcode_q;
   assign funct          = funct_q;
   assign illegal        = illegal_q;
   assign err_timeout    = err_q;

endmodule
